// File: rtl/mcu_raster.sv
// mcu_raster: double-banked MCU-column to raster reorder for 128x8 pixel strips.
// Define MCU_RASTER_OVF_EN to add a sticky ovf output flagging writes refused while full.
module mcu_raster (
   input  logic            clk,
   input  logic            nrst,
   input  logic [7:0][7:0] din,
   input  logic            din_valid,
   output logic            din_ready,
   output logic [7:0]      dout,
   output logic            dout_valid,
   input  logic            dout_ready
`ifdef MCU_RASTER_OVF_EN
   ,
   output logic            ovf
`endif
);
   logic [1:0]      full;
   logic            wr_sel, rd_sel;
   logic [6:0]      wr_cnt;
   logic [9:0]      rd_cnt;
   logic            rd_vld;
   logic [2:0]      rd_row_q;
   logic [7:0][7:0] rd_row;
   logic [7:0]      rd_data;
   logic [1:0]      buf_cnt;
   logic [7:0]      buf1;
   logic            wr_en, rd_en, pop, push_hi;

   assign din_ready  = ~full[wr_sel];
   assign dout_valid = |buf_cnt;
   assign wr_en      = din_valid & din_ready;
   assign pop        = dout_valid & dout_ready;
   // Issue only while the buffer, counting this cycle's pop, has room beyond the read in flight.
   assign rd_en      = full[rd_sel] & (({1'b0, buf_cnt} + {2'b0, rd_vld}) < (3'd2 + {2'b0, pop}));
   assign push_hi    = buf_cnt[1] | (buf_cnt[0] & ~pop);
   assign rd_data    = rd_row[rd_row_q];

   for (genvar i = 0; i < 8; i++) begin : g_ram
      logic [7:0] ram [2][128];
      logic [7:0] q;
      always_ff @(posedge clk) begin
         if (wr_en) ram[wr_sel][wr_cnt] <= din[i];
         if (rd_en) q <= ram[rd_sel][rd_cnt[6:0]];
      end
      assign rd_row[i] = q;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         full     <= '0;
         wr_sel   <= 1'b0;
         rd_sel   <= 1'b0;
         wr_cnt   <= '0;
         rd_cnt   <= '0;
         rd_vld   <= 1'b0;
         rd_row_q <= '0;
         buf_cnt  <= '0;
         buf1     <= '0;
         dout     <= '0;
      end else begin
         if (wr_en) begin
            wr_cnt <= wr_cnt + 7'd1;
            if (wr_cnt == 7'd127) begin
               full[wr_sel] <= 1'b1;
               wr_sel       <= ~wr_sel;
            end
         end
         if (rd_en) begin
            rd_cnt   <= rd_cnt + 10'd1;
            rd_row_q <= rd_cnt[9:7];
            if (rd_cnt == 10'd1023) begin
               full[rd_sel] <= 1'b0;
               rd_sel       <= ~rd_sel;
            end
         end
         rd_vld  <= rd_en;
         buf_cnt <= buf_cnt + {1'b0, rd_vld} - {1'b0, pop};
         if (pop) dout <= buf1;
         if (rd_vld) begin
            if (push_hi) buf1 <= rd_data;
            else dout <= rd_data;
         end
      end
   end

`ifdef MCU_RASTER_OVF_EN
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) ovf <= 1'b0;
      else if (din_valid & ~din_ready) ovf <= 1'b1;
   end
`endif
endmodule

// File: tb/tb_mcu_raster.sv
// tb_mcu_raster: directed bench for mcu_raster with a strip-level raster model and per-cycle checker.
module tb_mcu_raster;
   logic            clk = 1'b0;
   logic            nrst = 1'b0;
   logic [7:0][7:0] din = '0;
   logic            din_valid = 1'b0;
   logic            din_ready;
   logic [7:0]      dout;
   logic            dout_valid;
   logic            dout_ready = 1'b1;
`ifdef MCU_RASTER_OVF_EN
   logic            ovf;
`endif

   int         n_chk = 0, n_fail = 0;
   logic [7:0] exp_q [$];
   logic [7:0] col [128][8];
   int         col_cnt = 0, out_n = 0, stall_cnt = 0, cyc = 0, first_c = -1, last_c = -1;
   bit         pin_mode = 1'b0, rand_mode = 1'b0, ready_level = 1'b1, prev_stall = 1'b0;
   logic [7:0] prev_dout = '0;

   mcu_raster dut (
      .clk(clk),
      .nrst(nrst),
      .din(din),
      .din_valid(din_valid),
      .din_ready(din_ready),
      .dout(dout),
      .dout_valid(dout_valid),
      .dout_ready(dout_ready)
`ifdef MCU_RASTER_OVF_EN
      , .ovf(ovf)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(posedge clk) begin
      #1;
      dout_ready = rand_mode ? ($urandom_range(0, 1) == 1) : ready_level;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model: collect accepted columns; a complete strip yields its 1024 pixels row by row.
   always @(negedge clk) begin
      if (!nrst) begin
         exp_q.delete();
         col_cnt = 0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", dout_valid, 1);
            check("hold_data", dout, prev_dout);
         end
         if (dout_valid && dout_ready) begin
            check("queue_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("pixel", dout, exp_q.pop_front());
            if (pin_mode) check("pin_formula", dout, {out_n[9:7], out_n[4:0]});
            if (out_n == 0) first_c = cyc;
            last_c = cyc;
            out_n++;
         end
         prev_stall = dout_valid && !dout_ready;
         prev_dout = dout;
         if (din_valid && !din_ready) stall_cnt++;
         if (din_valid && din_ready) begin
            for (int i = 0; i < 8; i++) col[col_cnt][i] = din[i];
            col_cnt++;
            if (col_cnt == 128) begin
               for (int n = 0; n < 1024; n++) exp_q.push_back(col[n % 128][n / 128]);
               col_cnt = 0;
            end
         end
      end
   end

   task automatic send(input int pat, input int beats, input bit hold);
      for (int k = 0; k < beats; k++) begin
         int t;
         for (int i = 0; i < 8; i++)
            din[i] = (pat == 0) ? {i[2:0], k[4:0]} : 8'(i * 37 + k * 11 + pat * 91);
         din_valid = 1'b1;
         t = 0;
         @(negedge clk);
         while (!din_ready && t < 5000) begin
            @(negedge clk);
            t++;
         end
         if (t == 5000) check("accept_timeout", din_ready, 1);
         @(posedge clk);
         #1;
      end
      if (!hold) din_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 20000) begin
         @(posedge clk);
         t++;
      end
      check("drain_done", exp_q.size(), 0);
      repeat (4) @(posedge clk);
      #1;
      check("idle_after_drain", dout_valid, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_dout_valid", dout_valid, 0);
      check("rst_dout", dout, 0);
      check("rst_din_ready", din_ready, 1);
`ifdef MCU_RASTER_OVF_EN
      check("rst_ovf", ovf, 0);
`endif
      nrst = 1'b1;

      // single strip, known pattern, latency
      pin_mode = 1'b1;
      out_n = 0;
      send(0, 128, 0);
      check("model_n0", exp_q[0], 8'h00);
      check("model_n130", exp_q[130], 8'h22);
      check("model_n1023", exp_q[1023], 8'hFF);
      check("lat_e0", dout_valid, 0);
      @(posedge clk); #1;
      check("lat_e1", dout_valid, 0);
      @(posedge clk); #1;
      check("lat_e2", dout_valid, 1);
      check("first_pixel", dout, 8'h00);
      @(posedge clk); #1;
      check("second_pixel", dout, 8'h01);
      drain();
      check("t1_count", out_n, 1024);
      pin_mode = 1'b0;

      // three strips back to back
      out_n = 0;
      stall_cnt = 0;
      send(1, 128, 1);
      send(2, 128, 1);
      send(3, 128, 0);
      drain();
      check("t2_count", out_n, 3072);
      check("t2_no_gaps", last_c - first_c + 1, 3072);
      check("t2_stall_cycles", stall_cnt, 896);

      // random backpressure
      rand_mode = 1'b1;
      out_n = 0;
      send(4, 128, 1);
      send(5, 128, 0);
      drain();
      rand_mode = 1'b0;
      check("t3_count", out_n, 2048);

      // reset mid-strip while draining
      out_n = 0;
      send(6, 128, 0);
      for (int t = 0; t < 5000 && out_n < 240; t++) @(posedge clk);
      #1;
      send(7, 60, 1);
      check("t4_midway", (out_n > 250 && out_n < 1024), 1);
      nrst = 1'b0;
      din_valid = 1'b0;
      #1;
      check("rst4_dout", dout, 0);
      check("rst4_dout_valid", dout_valid, 0);
      check("rst4_din_ready", din_ready, 1);
      repeat (2) @(posedge clk);
      #1;
      nrst = 1'b1;
      out_n = 0;
      send(8, 128, 0);
      drain();
      check("t4_count", out_n, 1024);

      // both banks full with din_valid held
      ready_level = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      out_n = 0;
      send(9, 128, 1);
      send(10, 128, 1);
      stall_cnt = 0;
      for (int c = 0; c < 50; c++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 8; i++) din[i] = 8'(c * 13 + i);
      end
      check("t5_din_ready", din_ready, 0);
      check("t5_stall_cycles", stall_cnt, 50);
`ifdef MCU_RASTER_OVF_EN
      check("t5_ovf_set", ovf, 1);
`endif
      din_valid = 1'b0;
      ready_level = 1'b1;
      drain();
      check("t5_count", out_n, 2048);
`ifdef MCU_RASTER_OVF_EN
      check("t5_ovf_sticky", ovf, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
